pc_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of instruction_memory. Holds the program counter, drives instruction_memory.readAddress, and computes next-PC (sequential, branch, jump, jump-register). Captures the returned instruction and PC+4 into an IF/ID register for the decode stage. Supports stall and flush; there are no branch delay slots, so a taken redirect squashes the fetched instruction.

---
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 tb/tb_pc_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Latency: instruction at readAddress appears on if_id_* one clock edge later.
// Backpressure: stall holds PC, IF/ID and error flag; redirect/flush inputs are ignored while stalled.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   stall, flush        hazard-unit controls
//   branch_taken/offset conditional branch from ID (offset in words)
//   jump/jump_index     J/JAL from ID
//   jump_reg/jr_target  JR/JALR from ID
//   instruction         combinational read data from instruction memory
//   readAddress         current PC
//   if_id_*             registered instruction, its PC+4 and valid flag
//   misaligned_err      sticky flag for JR targets with nonzero low bits
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic [31:0] instruction,
    output logic [31:0] readAddress,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        misaligned_err
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_vld_q, ifid_vld_d;
    logic        mis_err_q, mis_err_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic        redirect;

    // Redirect targets are relative to the instruction currently held in ID.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_tgt   = ifid_pc4_q + (branch_offset << 2);
        j_tgt    = {ifid_pc4_q[31:28], jump_index, 2'b00};
        jr_tgt   = {jr_target[31:2], 2'b00};
    end

    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        mis_err_d    = mis_err_q;
        redirect     = 1'b0;

        if (!stall) begin
            // Redirects only come from a real instruction in ID; a bubble cannot branch.
            if (ifid_vld_q && jump_reg) begin
                redirect = 1'b1;
                pc_d     = jr_tgt;
                if (jr_target[1:0] != 2'b00) begin
                    mis_err_d = 1'b1;
                end
            end else if (ifid_vld_q && jump) begin
                redirect = 1'b1;
                pc_d     = j_tgt;
            end else if (ifid_vld_q && branch_taken) begin
                redirect = 1'b1;
                pc_d     = br_tgt;
            end else begin
                pc_d = pc_plus4;
            end

            // No delay slots: a taken redirect squashes the word fetched this cycle.
            if (redirect || flush) begin
                ifid_instr_d = NOP_WORD;
                ifid_pc4_d   = 32'd0;
                ifid_vld_d   = 1'b0;
            end else begin
                ifid_instr_d = instruction;
                ifid_pc4_d   = pc_plus4;
                ifid_vld_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'd0;
            ifid_vld_q   <= 1'b0;
            mis_err_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_vld_q   <= ifid_vld_d;
            mis_err_q    <= mis_err_d;
        end
    end

    assign readAddress       = pc_q;
    assign if_id_instruction = ifid_instr_q;
    assign if_id_pc_plus4    = ifid_pc4_q;
    assign if_id_valid       = ifid_vld_q;
    assign misaligned_err    = mis_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then random traffic.
// Outputs are compared against a reference model every negative clock edge.
// Inputs are driven 1 time unit after each rising edge.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] instruction;
    logic [31:0] readAddress;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misaligned_err;

    logic [31:0] salt;
    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_offset    (branch_offset),
        .jump             (jump),
        .jump_index       (jump_index),
        .jump_reg         (jump_reg),
        .jr_target        (jr_target),
        .instruction      (instruction),
        .readAddress      (readAddress),
        .if_id_instruction(if_id_instruction),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .misaligned_err   (misaligned_err)
    );

    // Instruction memory: word i holds 0x1000_0000 + i, optionally scrambled by salt.
    function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic [31:0] s);
        return (32'h1000_0000 + (addr >> 2)) ^ s;
    endfunction

    assign instruction = mem_word(readAddress, salt);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural state of the fetch stage.
    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_vld, m_err;
    logic [31:0] nxt;
    logic        redir;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc  = RESET_PC;
            m_ins = NOP_WORD;
            m_pc4 = 0;
            m_vld = 0;
            m_err = 0;
        end else if (!stall) begin
            redir = m_vld && (jump_reg || jump || branch_taken);
            if (m_vld && jump_reg) begin
                nxt = jr_target & 32'hFFFF_FFFC;
                if (jr_target % 4 != 0) m_err = 1;
            end else if (m_vld && jump) begin
                nxt = (m_pc4 & 32'hF000_0000) | (32'(jump_index) * 4);
            end else if (m_vld && branch_taken) begin
                nxt = m_pc4 + branch_offset * 4;
            end else begin
                nxt = m_pc + 4;
            end
            if (redir || flush) begin
                m_ins = NOP_WORD;
                m_pc4 = 0;
                m_vld = 0;
            end else begin
                m_ins = mem_word(m_pc, salt);
                m_pc4 = m_pc + 4;
                m_vld = 1;
            end
            m_pc = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_pc", readAddress, m_pc);
        chk("model_ins", if_id_instruction, m_ins);
        chk("model_pc4", if_id_pc_plus4, m_pc4);
        chk("model_vld", {31'd0, if_id_valid}, {31'd0, m_vld});
        chk("model_err", {31'd0, misaligned_err}, {31'd0, m_err});
        chk("pc_align", {30'd0, readAddress[1:0]}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        stall = 0; flush = 0; branch_taken = 0; branch_offset = 0;
        jump = 0; jump_index = 0; jump_reg = 0; jr_target = 0;
    endtask

    initial begin
        reset_n = 0;
        salt = 0;
        clear_ctl();
        #2;
        chk("rst_pc", readAddress, RESET_PC);
        chk("rst_ins", if_id_instruction, NOP_WORD);
        chk("rst_pc4", if_id_pc_plus4, 32'd0);
        chk("rst_vld", {31'd0, if_id_valid}, 32'd0);
        chk("rst_err", {31'd0, misaligned_err}, 32'd0);
        tick();
        reset_n = 1;
        chk("seq_pc0", readAddress, 32'h0);
        tick();
        chk("seq_pc4", readAddress, 32'h4);
        chk("seq_ins0", if_id_instruction, 32'h1000_0000);
        chk("seq_pc4_0", if_id_pc_plus4, 32'h4);
        chk("seq_vld", {31'd0, if_id_valid}, 32'd1);
        tick();
        chk("seq_pc8", readAddress, 32'h8);
        chk("seq_ins1", if_id_instruction, 32'h1000_0001);

        // Stall three cycles at PC 8.
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", readAddress, 32'h8);
            chk("stall_pc4", if_id_pc_plus4, 32'h8);
        end
        stall = 0;
        tick();
        chk("resume_pc", readAddress, 32'hC);
        chk("resume_ins", if_id_instruction, 32'h1000_0002);
        tick();
        chk("pre_br_pc4", if_id_pc_plus4, 32'h10);

        // Backward branch of two words from ID PC+4 = 0x10.
        branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        tick();
        chk("br_pc", readAddress, 32'h8);
        chk("br_vld", {31'd0, if_id_valid}, 32'd0);
        chk("br_ins", if_id_instruction, NOP_WORD);
        clear_ctl();
        tick();

        // All redirects at once: JR wins.
        jump_reg = 1; jr_target = 32'h40; jump = 1; jump_index = 26'h100;
        branch_taken = 1; branch_offset = 32'd5;
        tick();
        chk("prio_jr", readAddress, 32'h40);
        clear_ctl();
        tick();
        jump = 1; jump_index = 26'h100; branch_taken = 1; branch_offset = 32'd5;
        tick();
        chk("prio_j", readAddress, 32'h400);
        // ID now holds a bubble, so the held jump must be ignored.
        tick();
        chk("ign_invalid", readAddress, 32'h404);
        clear_ctl();

        // Misaligned JR target.
        jump_reg = 1; jr_target = 32'h43;
        tick();
        chk("mis_pc", readAddress, 32'h40);
        chk("mis_err", {31'd0, misaligned_err}, 32'd1);
        clear_ctl();
        tick();
        chk("mis_sticky", {31'd0, misaligned_err}, 32'd1);
        chk("mis_nostall", readAddress, 32'h44);

        // Wrap past the top of the address space.
        jump_reg = 1; jr_target = 32'hFFFF_FFF8;
        tick();
        clear_ctl();
        tick();
        chk("wrap_top", readAddress, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", readAddress, 32'h0);
        chk("wrap_pc4", if_id_pc_plus4, 32'h0);
        chk("wrap_vld", {31'd0, if_id_valid}, 32'd1);
        for (int k = 0; k < 9; k++) tick();
        chk("pre_rst_pc", readAddress, 32'h24);

        // Asynchronous reset between edges.
        #2;
        reset_n = 0;
        #1;
        chk("arst_pc", readAddress, RESET_PC);
        chk("arst_vld", {31'd0, if_id_valid}, 32'd0);
        chk("arst_err", {31'd0, misaligned_err}, 32'd0);
        chk("arst_pc4", if_id_pc_plus4, 32'd0);
        tick();
        reset_n = 1;
        tick();
        chk("restart_pc", readAddress, RESET_PC + 32'd4);

        // Random traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n       = 1;
            salt          = $urandom;
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 6) == 0);
            jump_reg      = ($urandom_range(0, 10) == 0);
            jump          = ($urandom_range(0, 8) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            branch_offset = ($urandom_range(0, 1) == 1) ? $urandom
                                                        : 32'($signed($urandom_range(0, 64)) - 32);
            jump_index    = 26'($urandom);
            jr_target     = $urandom;
            if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
            if (i % 700 == 350) begin
                #2;
                reset_n = 0;
            end
            tick();
        end
        reset_n = 1;
        clear_ctl();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
